sim_clk_div_gen: RTL and testbench
==================================

SIM_CLK_DIV_GEN -- requirements
Module: sim_clk_div_gen

Interface
- REQ-001 Parameter NCH, default 2: number of independent generated clock channels, range 1..16.
- REQ-002 Parameter DIV_W, default 8: width of each channel's half-period field.
- REQ-003 Parameter CNT_W, default 32: width of each channel's rising-edge counter.
- REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-005 Port rst, input, 1: reset, synchronous, active-high.
- REQ-006 Port en, input, NCH: per-channel run enable; bit i controls channel i.
- REQ-007 Port half_period, input, NCH*DIV_W: per-channel half-period in clk cycles; channel i uses bits [i*DIV_W +: DIV_W].
- REQ-008 Port clk_out, output, NCH: registered divided clock per channel.
- REQ-009 Port tick, output, NCH: one-cycle pulse, coincident with each 0->1 transition of clk_out[i].
- REQ-010 Port count, output, NCH*CNT_W: per-channel count of clk_out rising edges; channel i in [i*CNT_W +: CNT_W].

Function
- REQ-011 Each channel SHALL hold an internal DIV_W-bit phase counter cnt[i]; channels are fully independent.
- REQ-012 Effective half-period H[i] SHALL be half_period[i], except a value of 0 SHALL be treated as 1.
- REQ-013 On a clk edge with en[i]=1 and cnt[i] >= H[i]-1, the block SHALL set cnt[i] to 0 and invert clk_out[i].
- REQ-014 On a clk edge with en[i]=1 and cnt[i] < H[i]-1, the block SHALL increment cnt[i] and hold clk_out[i].
- REQ-015 clk_out[i] SHALL therefore toggle on every H[i]-th enabled edge: period 2*H[i] clk cycles, 50% duty.
- REQ-016 tick[i] SHALL be 1 for exactly the cycle following the edge where clk_out[i] goes 0->1, otherwise 0; it is registered alongside clk_out[i].
- REQ-017 count[i] SHALL increment by 1 on the same edge that sets tick[i], wrapping from 2^CNT_W-1 to 0 without saturation.
- REQ-018 With en[i]=0 the block SHALL freeze cnt[i], clk_out[i] and count[i], and drive tick[i]=0; re-enabling SHALL resume from the frozen phase.
- REQ-019 A change of half_period[i] SHALL take effect at the next edge; if the new H[i]-1 <= the current cnt[i], the channel SHALL toggle on that edge (no counter wrap through 2^DIV_W).
- REQ-020 half_period = 2^DIV_W-1 SHALL produce a period of 2*(2^DIV_W-1) cycles with no overflow of cnt[i].

Reset
- REQ-021 With rst=1 on a clk edge, every channel SHALL set cnt=0, clk_out=0, tick=0, count=0, regardless of en.
- REQ-022 rst SHALL take priority over all other inputs, including mid-period; the first enabled edge after rst deassertion SHALL count as phase 0.

Configuration
- REQ-023 Macro SIM_CLK_DIV_GEN_DEBUG_EN: when defined, the block SHALL $display "<time> ch<i> tick <count>" on every edge where tick[i] is set, count being the new value.
- REQ-024 Without SIM_CLK_DIV_GEN_DEBUG_EN the block SHALL contain no display code and SHALL be cycle-identical in all outputs.

Verification
- REQ-025 Reset then en=2'b11, H0=1, H1=3 -> clk_out[0] period 2 clk, clk_out[1] period 6 clk; first clk_out[1] rise after 3 enabled edges; count after 60 cycles = 30 and 10.
- REQ-026 H0=0 -> identical waveform to H0=1.
- REQ-027 H0=4 running, drop en[0] for 5 cycles at cnt=2, then restore -> clk_out/count frozen, tick=0, next toggle 2 edges after re-enable.
- REQ-028 H0=8, cnt[0]=6, change to H0=3 -> toggle on the next edge, then period 6 clk.
- REQ-029 CNT_W=4, H0=1, 17 rising edges -> count[0] wraps 15->0 then reads 1; tick still pulses every 2 cycles.
- REQ-030 Assert rst for 1 cycle mid-period on all channels -> all outputs 0 next cycle; with SIM_CLK_DIV_GEN_DEBUG_EN the log lists one line per tick, with identical waveforms to a build without the macro.

Source files
------------

// File: rtl/sim_clk_div_gen.sv
// Per-channel programmable clock divider (period 2*H clk, 50% duty) with rise tick and rise counter.
// Outputs registered, one clk after the deciding edge; no backpressure. Optional log macro: SIM_CLK_DIV_GEN_DEBUG_EN.
module sim_clk_div_gen #(
   parameter int NCH   = 2,
   parameter int DIV_W = 8,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en,
   input  logic [NCH*DIV_W-1:0] half_period,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH-1:0]       tick,
   output logic [NCH*CNT_W-1:0] count
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DIV_W-1:0] w_hp;
      logic [DIV_W-1:0] w_h;
      logic             w_wrap;
      logic             w_rise;
      logic [DIV_W-1:0] r_cnt;
      logic             r_clk;
      logic             r_tick;
      logic [CNT_W-1:0] r_count;

      assign w_hp = half_period[i*DIV_W +: DIV_W];
      assign w_h  = (w_hp == '0) ? DIV_W'(1) : w_hp;
      // >= rather than == so a shrunk half-period toggles at once instead of wrapping cnt
      assign w_wrap = (r_cnt >= (w_h - DIV_W'(1)));
      assign w_rise = en[i] & w_wrap & ~r_clk;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            r_count <= '0;
         end else begin
            r_tick <= w_rise;
            if (en[i]) begin
               if (w_wrap) begin
                  r_cnt <= '0;
                  r_clk <= ~r_clk;
               end else begin
                  r_cnt <= r_cnt + DIV_W'(1);
               end
            end
            if (w_rise) begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end

      assign clk_out[i]                = r_clk;
      assign tick[i]                   = r_tick;
      assign count[i*CNT_W +: CNT_W]   = r_count;

`ifdef SIM_CLK_DIV_GEN_DEBUG_EN
      always @(posedge clk) begin
         if (!rst && w_rise) begin
            $display("%0t ch%0d tick %0d", $time, i, r_count + CNT_W'(1));
         end
      end
`endif
   end

endmodule

// File: tb/tb_sim_clk_div_gen.sv
// Directed bench for sim_clk_div_gen: expected tick events are queued by stimulus and
// consumed by a monitor whenever a tick appears; level/count checks are made inline.
module tb_sim_clk_div_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  en = '0;
   logic [15:0] half_period = '0;
   logic [1:0]  clk_out;
   logic [1:0]  tick;
   logic [63:0] count;

   logic        en_w = 1'b0;
   logic [7:0]  hp_w = '0;
   logic        clk_out_w;
   logic        tick_w;
   logic [3:0]  count_w;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int c0;

   typedef struct {
      int cyc;
      int cnt;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   ev_t q2[$];

   sim_clk_div_gen #(.NCH(2), .DIV_W(8), .CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .half_period (half_period),
      .clk_out     (clk_out),
      .tick        (tick),
      .count       (count)
   );

   sim_clk_div_gen #(.NCH(1), .DIV_W(8), .CNT_W(4)) dut_w (
      .clk         (clk),
      .rst         (rst),
      .en          (en_w),
      .half_period (hp_w),
      .clk_out     (clk_out_w),
      .tick        (tick_w),
      .count       (count_w)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int ch, input int cnt);
      ev_t e;
      bit  ok;
      ok = 1'b1;
      e  = '{0, 0};
      case (ch)
         0:       if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
         1:       if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
         default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
      endcase
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tick_unexpected ch%0d: got tick at cyc %0d count %0d, required no tick", ch, cyc, cnt);
      end else if (e.cyc != cyc || e.cnt != cnt) begin
         errors++;
         $display("FAIL tick ch%0d: got cyc %0d count %0d, required cyc %0d count %0d", ch, cyc, cnt, e.cyc, e.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (tick[0]) mon(0, int'(count[31:0]));
      if (tick[1]) mon(1, int'(count[63:32]));
      if (tick_w)  mon(2, int'(count_w));
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      en   = '0;
      en_w = 1'b0;
      @(negedge clk);
      chk("rst_clk_out", 64'(clk_out), 64'd0);
      chk("rst_tick", 64'(tick), 64'd0);
      chk("rst_count", count, 64'd0);
      chk("rst_count_w", 64'(count_w), 64'd0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish by 200000");
      $fatal(1);
   end

   initial begin
      // H0=1, H1=3: periods 2 and 6, ch1 first rise on third edge
      do_reset();
      c0 = cyc;
      en = 2'b11;
      half_period = {8'd3, 8'd1};
      for (int k = 1; k <= 30; k++) q0.push_back('{c0 + 2*k - 1, k});
      for (int k = 0; k < 10; k++) q1.push_back('{c0 + 3 + 6*k, k + 1});
      idle(60);
      chk("count0_after60", count[31:0], 64'd30);
      chk("count1_after60", count[63:32], 64'd10);
      en = 2'b00;

      // H0=0 behaves as H0=1; disabled ch1 stays frozen
      do_reset();
      c0 = cyc;
      en = 2'b01;
      half_period = {8'd0, 8'd0};
      for (int k = 1; k <= 5; k++) q0.push_back('{c0 + 2*k - 1, k});
      for (int j = 1; j <= 10; j++) begin
         idle(1);
         chk("h0zero_clk_out0", 64'(clk_out[0]), 64'(j % 2));
      end
      chk("h0zero_count0", count[31:0], 64'd5);
      chk("h0zero_count1", count[63:32], 64'd0);
      en = 2'b00;

      // H0=4, disable for 5 edges while clk_out high and cnt=2
      do_reset();
      c0 = cyc;
      en = 2'b01;
      half_period = {8'd0, 8'd4};
      q0.push_back('{c0 + 4, 1});
      q0.push_back('{c0 + 17, 2});
      q0.push_back('{c0 + 25, 3});
      idle(6);
      chk("frz_pre_clk_out0", 64'(clk_out[0]), 64'd1);
      en = 2'b00;
      for (int j = 0; j < 5; j++) begin
         idle(1);
         chk("frz_clk_out0", 64'(clk_out[0]), 64'd1);
         chk("frz_tick0", 64'(tick[0]), 64'd0);
         chk("frz_count0", count[31:0], 64'd1);
      end
      en = 2'b01;
      idle(1);
      chk("frz_resume1_clk_out0", 64'(clk_out[0]), 64'd1);
      idle(1);
      chk("frz_resume2_clk_out0", 64'(clk_out[0]), 64'd0);
      idle(13);
      chk("frz_count0_end", count[31:0], 64'd3);
      en = 2'b00;

      // H0=8 shrunk to 3 when cnt=6: toggle next edge, then period 6
      do_reset();
      c0 = cyc;
      en = 2'b01;
      half_period = {8'd0, 8'd8};
      q0.push_back('{c0 + 7, 1});
      q0.push_back('{c0 + 13, 2});
      q0.push_back('{c0 + 19, 3});
      idle(6);
      chk("hchg_pre_clk_out0", 64'(clk_out[0]), 64'd0);
      half_period = {8'd0, 8'd3};
      idle(1);
      chk("hchg_clk_out0", 64'(clk_out[0]), 64'd1);
      idle(13);
      chk("hchg_count0", count[31:0], 64'd3);
      en = 2'b00;

      // maximum half-period 255
      do_reset();
      c0 = cyc;
      en = 2'b01;
      half_period = {8'd0, 8'd255};
      q0.push_back('{c0 + 255, 1});
      q0.push_back('{c0 + 765, 2});
      idle(254);
      chk("hmax_clk_out0_low", 64'(clk_out[0]), 64'd0);
      idle(1);
      chk("hmax_clk_out0_high", 64'(clk_out[0]), 64'd1);
      idle(255);
      chk("hmax_clk_out0_fall", 64'(clk_out[0]), 64'd0);
      idle(256);
      chk("hmax_count0", count[31:0], 64'd2);
      en = 2'b00;

      // reset mid-period with both channels enabled
      do_reset();
      c0 = cyc;
      en = 2'b11;
      half_period = {8'd5, 8'd3};
      q0.push_back('{c0 + 3, 1});
      q1.push_back('{c0 + 5, 1});
      idle(7);
      chk("mrst_pre_clk_out", 64'(clk_out), 64'd2);
      chk("mrst_pre_count1", count[63:32], 64'd1);
      rst = 1'b1;
      idle(1);
      chk("mrst_clk_out", 64'(clk_out), 64'd0);
      chk("mrst_tick", 64'(tick), 64'd0);
      chk("mrst_count", count, 64'd0);
      rst = 1'b0;
      q0.push_back('{c0 + 11, 1});
      q1.push_back('{c0 + 13, 1});
      idle(8);
      chk("mrst_post_count0", count[31:0], 64'd1);
      chk("mrst_post_count1", count[63:32], 64'd1);
      en = 2'b00;

      // 4-bit counter wraps 15 -> 0 -> 1 over 17 rises
      do_reset();
      c0 = cyc;
      en_w = 1'b1;
      hp_w = 8'd1;
      for (int k = 0; k <= 16; k++) q2.push_back('{c0 + 1 + 2*k, (k + 1) % 16});
      idle(33);
      chk("wrap_count_w", 64'(count_w), 64'd1);
      en_w = 1'b0;

      idle(3);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q2_drained", 64'(q2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
